simple_bus_arbiter: RTL
=======================

Name: simple_bus_arbiter

Overview:
- Parametrised N-master / 1-slave controller for the simple_bus protocol (req/gnt, start/rdy, addr/mode/data).
- Sits between several bus masters and one slave port.
- Performs fair round-robin arbitration and registered request forwarding.
- Adds a response-timeout error path that the bare interface lacks.

Parameters:
- NUM_MASTERS, 4, number of master channels (2..16)
- ADDR_W, 8, address width
- DATA_W, 8, data width
- MODE_W, 2, mode field width (passed through opaquely)
- TIMEOUT, 16, max cycles to wait for s_rdy; 0 disables the timeout

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous active-high reset
- m_req  in  NUM_MASTERS  per-master bus request
- m_start  in  NUM_MASTERS  per-master transfer start (valid only while granted)
- m_addr  in  NUM_MASTERS*ADDR_W  packed per-master address, master i at [i*ADDR_W +: ADDR_W]
- m_mode  in  NUM_MASTERS*MODE_W  packed per-master mode
- m_wdata  in  NUM_MASTERS*DATA_W  packed per-master write data
- m_gnt  out  NUM_MASTERS  one-hot grant
- m_rdy  out  NUM_MASTERS  one-cycle completion pulse to the owner
- m_err  out  NUM_MASTERS  one-cycle timeout pulse to the owner
- m_rdata  out  DATA_W  registered read data, shared by all masters, valid with m_rdy
- s_start  out  1  one-cycle start pulse to the slave
- s_addr  out  ADDR_W  latched address
- s_mode  out  MODE_W  latched mode
- s_wdata  out  DATA_W  latched write data
- s_rdy  in  1  slave completion
- s_rdata  in  DATA_W  slave read data, valid with s_rdy
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset:
  - state = IDLE.
  - All outputs 0.
  - RR pointer = 0; timeout counter = 0.
  - Reset asserted mid-transfer aborts it immediately; no m_rdy or m_err is issued.
- FSM states:
  - IDLE: if any m_req is high, pick a winner by round-robin starting at the pointer. m_gnt[winner] goes high on the next edge -> GRANT. With no request, stay in IDLE.
  - GRANT:
    - If m_start[owner] is high: latch the owner's addr/mode/wdata into s_*, pulse s_start for 1 cycle, clear the counter -> WAIT_RDY.
    - Else if m_req[owner] drops: clear m_gnt, pointer = owner+1 (mod N) -> IDLE.
    - m_start from a non-owner is ignored.
  - WAIT_RDY:
    - Counter increments each cycle.
    - On s_rdy: m_rdata <= s_rdata, pulse m_rdy[owner], clear m_gnt, pointer = owner+1 -> IDLE.
    - If TIMEOUT != 0 and the counter reaches TIMEOUT-1 without s_rdy: pulse m_err[owner], clear m_gnt, pointer = owner+1 -> IDLE.
    - If s_rdy and timeout occur in the same cycle, s_rdy wins and no m_err is issued.
- Latency:
  - m_req -> m_gnt: 1 cycle.
  - m_start -> s_start: 1 cycle.
  - s_rdy -> m_rdy / m_gnt low: 1 cycle.
  - Minimum transfer: 4 cycles from req to rdy with a zero-wait slave.
- Re-arbitration: earliest in the cycle after m_rdy (IDLE), so back-to-back grants have one dead cycle.
- Handshake rules:
  - s_rdy is ignored outside WAIT_RDY.
  - m_gnt is one-hot or zero at all times.
  - s_addr, s_mode and s_wdata hold stable from s_start until the next start.
- Wrap-around: the pointer wraps from N-1 to 0. A lone requester is re-granted indefinitely.

Decomposition:
- Shared package simple_bus_pkg holds:
  - state enum (IDLE, GRANT, WAIT_RDY)
  - mode encoding constants (MODE_RD = 2'b00, MODE_WR = 2'b01)
  - default width localparams
- One sub-module: rr_arbiter.
  - Combinational.
  - Inputs: request vector and pointer.
  - Output: one-hot winner plus winner index.
  - Instantiated once inside simple_bus_arbiter.

Test Plan:
- Reset mid-WAIT_RDY: N=4; master 1 granted and started, rst pulsed -> m_gnt = 0, no m_rdy/m_err, busy = 0, and the next request from master 0 is granted first.
- Single transfer: m_req = 4'b0100, start with addr = 8'h3C, wdata = 8'hA5, s_rdy two cycles after s_start with s_rdata = 8'h5A -> m_gnt = 4'b0100 one cycle after req, s_addr = 8'h3C, m_rdy[2] pulse, m_rdata = 8'h5A.
- Fairness: m_req = 4'b1111 held, each master starts immediately on grant -> grant order 0, 1, 2, 3, 0, one dead cycle between grants.
- Timeout: TIMEOUT = 16, s_rdy never asserted -> m_err[owner] pulse exactly 16 cycles after s_start, no m_rdy, FSM back in IDLE.
- Race: s_rdy asserted in the same cycle as the timeout expiry -> m_rdy pulse, m_err stays 0.
- Abandon: master 3 granted, drops m_req without start -> m_gnt cleared next cycle, no s_start, pointer moves to 0.

Source files
------------

// File: rtl/simple_bus_pkg.sv
// Shared types and constants for the simple_bus master/slave arbiter.
package simple_bus_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    WAIT_RDY = 2'd2
  } state_e;

  localparam logic [1:0] MODE_RD = 2'b00;
  localparam logic [1:0] MODE_WR = 2'b01;

  localparam int DEF_NUM_MASTERS = 4;
  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_MODE_W      = 2;
  localparam int DEF_TIMEOUT     = 16;

  // Index of the master after idx, wrapping from n-1 back to 0.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i wins.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  logic found;
  int   cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= N) cand = cand - N;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/simple_bus_arbiter.sv
// N-master / 1-slave simple_bus controller: round-robin grant, registered
// request forwarding and a response timeout that reports m_err to the owner.
module simple_bus_arbiter
  import simple_bus_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MODE_W      = DEF_MODE_W,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_start,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*MODE_W-1:0] m_mode,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_gnt,
  output logic [NUM_MASTERS-1:0]        m_rdy,
  output logic [NUM_MASTERS-1:0]        m_err,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          s_start,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [MODE_W-1:0]             s_mode,
  output logic [DATA_W-1:0]             s_wdata,
  input  logic                          s_rdy,
  input  logic [DATA_W-1:0]             s_rdata,
  output logic                          busy
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [NUM_MASTERS-1:0] rdy_q, rdy_d;
  logic [NUM_MASTERS-1:0] err_q, err_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic                   s_start_q, s_start_d;
  logic [ADDR_W-1:0]      s_addr_q, s_addr_d;
  logic [MODE_W-1:0]      s_mode_q, s_mode_d;
  logic [DATA_W-1:0]      s_wdata_q, s_wdata_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [NUM_MASTERS-1:0] win_gnt;
  logic [IDX_W-1:0]       win_idx;
  logic [IDX_W-1:0]       next_ptr;
  logic                   timeout_hit;

  logic [ADDR_W-1:0] addr_lane  [NUM_MASTERS];
  logic [MODE_W-1:0] mode_lane  [NUM_MASTERS];
  logic [DATA_W-1:0] wdata_lane [NUM_MASTERS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_lane
      assign addr_lane[gi]  = m_addr[gi*ADDR_W +: ADDR_W];
      assign mode_lane[gi]  = m_mode[gi*MODE_W +: MODE_W];
      assign wdata_lane[gi] = m_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_arbiter #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i (m_req),
    .ptr_i (ptr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx)
  );

  assign next_ptr    = IDX_W'(wrap_inc(int'(owner_q), NUM_MASTERS));
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    rdy_d     = '0;
    err_d     = '0;
    rdata_d   = rdata_q;
    s_start_d = 1'b0;
    s_addr_d  = s_addr_q;
    s_mode_d  = s_mode_q;
    s_wdata_d = s_wdata_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (|m_req) begin
          gnt_d   = win_gnt;
          owner_d = win_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (m_start[owner_q]) begin
          s_addr_d  = addr_lane[owner_q];
          s_mode_d  = mode_lane[owner_q];
          s_wdata_d = wdata_lane[owner_q];
          s_start_d = 1'b1;
          cnt_d     = '0;
          state_d   = WAIT_RDY;
        end else if (!m_req[owner_q]) begin
          gnt_d   = '0;
          ptr_d   = next_ptr;
          state_d = IDLE;
        end
      end
      WAIT_RDY: begin
        cnt_d = cnt_q + 1'b1;
        // s_rdy takes priority over a timeout expiring in the same cycle.
        if (s_rdy) begin
          rdata_d = s_rdata;
          rdy_d   = gnt_q;
          gnt_d   = '0;
          ptr_d   = next_ptr;
          state_d = IDLE;
        end else if (timeout_hit) begin
          err_d   = gnt_q;
          gnt_d   = '0;
          ptr_d   = next_ptr;
          state_d = IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      gnt_q     <= '0;
      rdy_q     <= '0;
      err_q     <= '0;
      rdata_q   <= '0;
      s_start_q <= 1'b0;
      s_addr_q  <= '0;
      s_mode_q  <= '0;
      s_wdata_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      rdy_q     <= rdy_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      s_start_q <= s_start_d;
      s_addr_q  <= s_addr_d;
      s_mode_q  <= s_mode_d;
      s_wdata_q <= s_wdata_d;
      cnt_q     <= cnt_d;
    end
  end

  assign m_gnt   = gnt_q;
  assign m_rdy   = rdy_q;
  assign m_err   = err_q;
  assign m_rdata = rdata_q;
  assign s_start = s_start_q;
  assign s_addr  = s_addr_q;
  assign s_mode  = s_mode_q;
  assign s_wdata = s_wdata_q;
  assign busy    = (state_q != IDLE);

endmodule
